snf_rxreq: RTL and testbench

//  SNF-side receiver for the CHI REQ channel driven by the HNF TXREQ port.

---
 rtl/snf_rxreq.sv | 149 ++++++++++++++
 tb/tb_snf_rxreq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/snf_rxreq.sv
// snf_rxreq_pkg: request flit layout shared by snf_rxreq and its users.
//
// snf_rxreq: SNF-side receiver for the CHI REQ channel.
//   Grants link-layer credits to the HNF transmitter and accepts request flits
//   only against granted credits. Accepted flits are buffered in a FIFO and
//   presented to the memory pipeline with a valid/ready handshake. Protocol
//   violations (flit without a credit, flit for another node) are flagged.
//
// Ports:
//   clock          in   single clock, all state updates on posedge
//   reset          in   synchronous, active-high
//   rxreqflit      in   request flit
//   rxreqflitv     in   flit valid; a transfer occurs every cycle it is high
//   rxreqflitpend  in   early flit indication (informational only)
//   rxreqlcrdv     out  one-cycle pulse grants one L-credit
//   crd_hold       in   stop issuing new credits; outstanding ones stay valid
//   req_flit       out  head-of-FIFO flit (0 while empty)
//   req_valid      out  FIFO non-empty
//   req_ready      in   downstream accepts; pop on req_valid & req_ready
//   crd_out        out  credits outstanding at the transmitter
//   err_nocrd      out  sticky: flit received with no credit outstanding
//   err_tgtid      out  sticky: flit received with TgtID != SNF_ID

package snf_rxreq_pkg;
  typedef struct packed {
    logic [47:0] addr;
    logic [2:0]  size;
    logic [6:0]  opcode;
    logic [11:0] txn_id;
    logic [10:0] src_id;
    logic [10:0] tgt_id;
    logic [3:0]  qos;
  } reqflit_t;
endpackage

module snf_rxreq
  import snf_rxreq_pkg::*;
#(
  parameter int         DEPTH   = 4,
  parameter int         MAX_CRD = 15,
  parameter logic [6:0] SNF_ID  = 7'h0
) (
  input  logic       clock,
  input  logic       reset,
  input  reqflit_t   rxreqflit,
  input  logic       rxreqflitv,
  input  logic       rxreqflitpend,
  output logic       rxreqlcrdv,
  input  logic       crd_hold,
  output reqflit_t   req_flit,
  output logic       req_valid,
  input  logic       req_ready,
  output logic [3:0] crd_out,
  output logic       err_nocrd,
  output logic       err_tgtid
);

  localparam int                PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [4:0]        DEPTH_C   = 5'(DEPTH);
  localparam logic [3:0]        MAX_CRD_C = 4'(MAX_CRD);

  reqflit_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]       count_q, count_d;
  logic [3:0]       crd_q, crd_d;
  logic             lcrdv_q, lcrdv_d;
  logic             err_nocrd_q, err_nocrd_d;
  logic             err_tgtid_q, err_tgtid_d;

  logic             has_crd;
  logic             tgt_ok;
  logic             consume;
  logic             acc;
  logic             pop;
  logic [4:0]       committed;

  // Early-flit hint carries no function in this receiver.
  logic unused_pend;
  assign unused_pend = rxreqflitpend;

  assign req_valid  = (count_q != 4'd0);
  assign req_flit   = req_valid ? mem_q[rd_ptr_q] : '0;
  assign rxreqlcrdv = lcrdv_q;
  assign crd_out    = crd_q;
  assign err_nocrd  = err_nocrd_q;
  assign err_tgtid  = err_tgtid_q;

  // NOTE: every variable gets a value on every path through this block, so
  // no latch is inferred; keep that property when adding signals.
  always_comb begin
    has_crd = (crd_q != 4'd0);
    tgt_ok  = (rxreqflit.tgt_id[6:0] == SNF_ID);
    // Any flit arriving against a credit uses it up, even if it is then
    // dropped for a bad target; only a credit-free flit leaves crd_out alone.
    consume = rxreqflitv & has_crd;
    acc     = consume & tgt_ok;
    pop     = req_valid & req_ready;

    crd_d   = crd_q + {3'b000, lcrdv_q} - {3'b000, consume};
    count_d = count_q + {3'b000, acc} - {3'b000, pop};

    // Explicit wrap so DEPTH need not be a power of two.
    wr_ptr_d = wr_ptr_q;
    if (acc) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_ONE;
    rd_ptr_d = rd_ptr_q;
    if (pop) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_ONE;

    // Grant against the state being loaded this edge so that outstanding
    // credits plus buffered flits can never exceed the buffer size; this is
    // why a legal push never needs a full check.
    committed = {1'b0, crd_d} + {1'b0, count_d};
    lcrdv_d   = !reset && !crd_hold && (committed < DEPTH_C) && (crd_d < MAX_CRD_C);

    err_nocrd_d = err_nocrd_q | (rxreqflitv & !has_crd);
    err_tgtid_d = err_tgtid_q | (consume & !tgt_ok);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= 4'd0;
      crd_q       <= 4'd0;
      lcrdv_q     <= 1'b0;
      err_nocrd_q <= 1'b0;
      err_tgtid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      crd_q       <= crd_d;
      lcrdv_q     <= lcrdv_d;
      err_nocrd_q <= err_nocrd_d;
      err_tgtid_q <= err_tgtid_d;
    end
  end

  // NOTE: the flit storage is deliberately not reset; an entry is only ever
  // read after it has been written, and req_flit is forced to 0 while empty.
  always_ff @(posedge clock) begin
    if (acc) mem_q[wr_ptr_q] <= rxreqflit;
  end

endmodule

// File: tb/tb_snf_rxreq.sv
// Self-checking bench for snf_rxreq: directed ramp/credit/error/reset
// scenarios followed by randomized traffic. The bench plays the transmitter,
// keeping its own credit count, and a scoreboard queue holds the flits that
// must emerge from the FIFO in order.
module tb_snf_rxreq;
  import snf_rxreq_pkg::*;

  localparam int         DEPTH   = 4;
  localparam int         MAX_CRD = 15;
  localparam logic [6:0] SNF_ID  = 7'h05;

  logic       clk = 1'b0;
  logic       reset;
  reqflit_t   rxreqflit;
  logic       rxreqflitv;
  logic       rxreqflitpend;
  logic       rxreqlcrdv;
  logic       crd_hold;
  reqflit_t   req_flit;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] crd_out;
  logic       err_nocrd;
  logic       err_tgtid;

  snf_rxreq #(.DEPTH(DEPTH), .MAX_CRD(MAX_CRD), .SNF_ID(SNF_ID)) dut (
    .clock        (clk),
    .reset        (reset),
    .rxreqflit    (rxreqflit),
    .rxreqflitv   (rxreqflitv),
    .rxreqflitpend(rxreqflitpend),
    .rxreqlcrdv   (rxreqlcrdv),
    .crd_hold     (crd_hold),
    .req_flit     (req_flit),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .crd_out      (crd_out),
    .err_nocrd    (err_nocrd),
    .err_tgtid    (err_tgtid)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: transmitter-side credit count, expected FIFO contents,
  // expected sticky error flags.
  reqflit_t sb[$];
  int       tx_crd    = 0;
  logic     exp_nocrd = 1'b0;
  logic     exp_tgtid = 1'b0;
  logic     hold_prev = 1'b0;

  // Values observed at the negedge of the most recent step.
  logic       lcrdv_s, valid_s, nocrd_s, tgtid_s;
  logic [3:0] crd_s;
  reqflit_t   flit_s;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // One clock cycle: check this cycle's outputs at negedge, advance the model
  // at posedge, then return 1 time unit later so the caller drives the next cycle.
  task automatic step();
    @(negedge clk);
    lcrdv_s = rxreqlcrdv;
    valid_s = req_valid;
    crd_s   = crd_out;
    nocrd_s = err_nocrd;
    tgtid_s = err_tgtid;
    flit_s  = req_flit;
    if (!reset) begin
      check("crd_out", crd_out, tx_crd);
      check("err_nocrd", err_nocrd, exp_nocrd);
      check("err_tgtid", err_tgtid, exp_tgtid);
      check("credit_sum", (int'(crd_out) + sb.size()) <= DEPTH, 1'b1);
      if (hold_prev) check("hold_lcrdv", rxreqlcrdv, 1'b0);
    end
    hold_prev = crd_hold;
    @(posedge clk);
    if (reset) begin
      tx_crd    = 0;
      sb.delete();
      exp_nocrd = 1'b0;
      exp_tgtid = 1'b0;
    end else begin
      if (rxreqflitv) begin
        if (tx_crd != 0) begin
          tx_crd--;
          if (rxreqflit.tgt_id[6:0] == SNF_ID) sb.push_back(rxreqflit);
          else exp_tgtid = 1'b1;
        end else begin
          exp_nocrd = 1'b1;
        end
      end
      if (lcrdv_s) tx_crd++;
    end
    #1;
  endtask

  task automatic drive_flit(input logic [6:0] tgt, input logic [47:0] addr, input logic [11:0] txn);
    rxreqflit.addr   = addr;
    rxreqflit.size   = 3'($urandom_range(0, 6));
    rxreqflit.opcode = 7'($urandom);
    rxreqflit.txn_id = txn;
    rxreqflit.src_id = 11'($urandom);
    rxreqflit.tgt_id = {4'($urandom), tgt};
    rxreqflit.qos    = 4'($urandom);
    rxreqflitv       = 1'b1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Credits must be granted in cycles 1..DEPTH after reset, then stop.
  task automatic ramp_check(input string tag);
    for (int c = 0; c < 8; c++) begin
      step();
      check({tag, "_lcrdv"}, lcrdv_s, (c >= 1 && c <= DEPTH));
      check({tag, "_crd"}, crd_s, (c <= 1) ? 0 : ((c - 1 > DEPTH) ? DEPTH : c - 1));
      if (c == 0) begin
        check({tag, "_valid0"}, valid_s, 1'b0);
        check({tag, "_errs0"}, {nocrd_s, tgtid_s}, 2'b00);
      end
    end
  endtask

  // Scoreboard monitor: pops an expected flit whenever the DUT hands one over.
  initial begin
    reqflit_t exp_f;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        check("req_valid", req_valid, sb.size() != 0);
        if (req_valid && req_ready) begin
          if (sb.size() == 0) begin
            n_total++;
            $display("FAIL sb_underflow: got flit %0h expected none at %0t", req_flit, $time);
          end else begin
            exp_f = sb.pop_front();
            check("req_flit", req_flit, exp_f);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int pulses;
    reset         = 1'b1;
    rxreqflit     = '0;
    rxreqflitv    = 1'b0;
    rxreqflitpend = 1'b0;
    crd_hold      = 1'b0;
    req_ready     = 1'b0;
    step();
    apply_reset();

    // T1: credit ramp after reset.
    ramp_check("t1");

    // T2: single request with downstream ready.
    req_ready = 1'b1;
    drive_flit(SNF_ID, 48'h1000, 12'h010);
    step();
    check("t2_valid_before", valid_s, 1'b0);
    check("t2_crd_before", crd_s, 4'd4);
    rxreqflitv = 1'b0;
    step();
    check("t2_valid_after", valid_s, 1'b1);
    check("t2_addr", flit_s.addr, 48'h1000);
    check("t2_crd_used", crd_s, 4'd3);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      pulses += int'(lcrdv_s);
    end
    check("t2_pulses", pulses, 1);
    check("t2_crd_back", crd_s, 4'd4);

    // T3: backpressure, four back-to-back flits.
    req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_flit(SNF_ID, 48'($urandom), 12'(i));
      step();
    end
    // T4: flit with no credit outstanding while the FIFO is full.
    drive_flit(SNF_ID, 48'hdead, 12'hbad);
    step();
    check("t3_crd_zero", crd_s, 4'd0);
    rxreqflitv = 1'b0;
    step();
    check("t4_err_nocrd", nocrd_s, 1'b1);
    check("t4_crd_zero", crd_s, 4'd0);
    check("t4_valid", valid_s, 1'b1);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      pulses += int'(lcrdv_s);
    end
    check("t3_no_lcrdv", pulses, 0);
    req_ready = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      pulses += int'(lcrdv_s);
    end
    check("t3_reissued", pulses, 4);
    check("t3_crd_full", crd_s, 4'd4);
    check("t3_drained", sb.size(), 0);

    // T5: wrong target consumes a credit but is not buffered.
    drive_flit(SNF_ID + 7'd1, 48'h2000, 12'h055);
    step();
    rxreqflitv = 1'b0;
    step();
    check("t5_err_tgtid", tgtid_s, 1'b1);
    check("t5_crd_dec", crd_s, 4'd3);
    check("t5_not_buffered", valid_s, 1'b0);
    for (int i = 0; i < 4; i++) step();
    check("t5_crd_back", crd_s, 4'd4);

    // T6: reset with flits buffered and both errors set.
    req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_flit(SNF_ID, 48'($urandom), 12'(i + 32));
      step();
    end
    rxreqflitv = 1'b0;
    step();
    check("t6_valid_before", valid_s, 1'b1);
    apply_reset();
    ramp_check("t6");

    // Randomized traffic with backpressure, credit hold and error injection.
    for (int n = 0; n < 3000; n++) begin
      req_ready     = ($urandom_range(0, 9) < 7);
      rxreqflitpend = 1'($urandom);
      if ($urandom_range(0, 49) == 0) crd_hold = !crd_hold;
      if (tx_crd > 0 && $urandom_range(0, 9) < 6) begin
        if ($urandom_range(0, 99) < 3) drive_flit(SNF_ID + 7'd1, 48'($urandom), 12'($urandom));
        else drive_flit(SNF_ID, {16'($urandom), 32'($urandom)}, 12'($urandom));
      end else if (tx_crd == 0 && $urandom_range(0, 99) < 2) begin
        drive_flit(SNF_ID, 48'($urandom), 12'($urandom));
      end else begin
        rxreqflitv = 1'b0;
      end
      step();
    end

    // Drain and let the credits refill.
    rxreqflitv = 1'b0;
    crd_hold   = 1'b0;
    req_ready  = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("final_drained", sb.size(), 0);
    check("final_crd", crd_s, 4'(DEPTH));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
